fun_dispatch: RTL and testbench
===============================

FUN_DISPATCH -- requirements
Module: fun_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand-queue entries (power of two, 2..16).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_a_i  input  8  multiplicand operand to enqueue.
REQ-005 SHALL have port in_b_i  input  8  cube-root operand to enqueue.
REQ-006 SHALL have port in_valid_i  input  1  producer offers {in_a_i,in_b_i}.
REQ-007 SHALL have port in_ready_o  output  1  queue can accept; push = in_valid_i & in_ready_o.
REQ-008 SHALL have port fun_a_o  output  8  operand a to compute stage, registered.
REQ-009 SHALL have port fun_b_o  output  8  operand b to compute stage, registered.
REQ-010 SHALL have port fun_start_o  output  1  one-cycle start pulse to compute stage.
REQ-011 SHALL have port fun_busy_i  input  1  compute stage busy.
REQ-012 SHALL have port fun_y_i  input  11  compute stage result, a*floor(cbrt(b)).
REQ-013 SHALL have port res_y_o  output  11  captured result.
REQ-014 SHALL have port res_valid_o  output  1  res_y_o holds an unconsumed result.
REQ-015 SHALL have port res_ready_i  input  1  consumer accepts; pop = res_valid_o & res_ready_i.
REQ-016 SHALL have port level_o  output  5  current queue occupancy, 0..DEPTH.

Function
REQ-017 SHALL store pushed operand pairs in a DEPTH-entry FIFO with wrapping read/write pointers, order preserved.
REQ-018 SHALL drive in_ready_o = (level_o != DEPTH); a push while full is impossible, even if a dequeue occurs the same cycle.
REQ-019 SHALL allow simultaneous push and dequeue when not full, level_o unchanged.
REQ-020 SHALL implement states IDLE, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE: if queue non-empty and res_valid_o low (or popped this cycle), SHALL dequeue head, load fun_a_o/fun_b_o, set fun_start_o=1, go to WAIT_BUSY on the same edge.
REQ-022 WAIT_BUSY: SHALL clear fun_start_o after exactly one cycle; on fun_busy_i=1 SHALL go to WAIT_DONE.
REQ-023 WAIT_DONE: on fun_busy_i=0 SHALL capture fun_y_i into res_y_o, set res_valid_o=1, go to IDLE.
REQ-024 SHALL hold fun_a_o/fun_b_o stable from start until leaving WAIT_DONE (compute stage samples operands late).
REQ-025 SHALL keep res_y_o/res_valid_o stable while res_valid_o=1 and res_ready_i=0; pop clears res_valid_o next edge.
REQ-026 Latency: push at edge N into empty queue, idle, free slot -> fun_start_o high after edge N+1.
REQ-027 At most one operation SHALL be outstanding; no start while in WAIT_BUSY or WAIT_DONE.

Reset
REQ-028 On rst_i=1 SHALL set state IDLE, pointers and level_o 0, fun_start_o 0, res_valid_o 0, res_y_o 0, fun_a_o 0, fun_b_o 0.
REQ-029 Reset mid-operation SHALL discard queued entries and the in-flight result; compute stage shares rst_i.
REQ-030 in_ready_o SHALL be 1 in the cycle after reset release.

Configuration
REQ-031 Macro FUN_DISPATCH_CNT_EN defined: SHALL add output done_cnt_o (16 bits), incremented per result capture, wrapping 0xFFFF->0, cleared by reset.
REQ-032 Macro undefined: port done_cnt_o and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 Push a=5,b=27, res_ready_i=1 -> one fun_start_o pulse, then res_y_o=15, res_valid_o=1.
REQ-034 Push a=255,b=255 -> res_y_o=1530; push a=200,b=0 -> res_y_o=0.
REQ-035 Hold res_ready_i=0, push DEPTH+2 pairs -> one result held stable, level_o reaches DEPTH, in_ready_o=0, later pushes refused.
REQ-036 Release res_ready_i -> all results emitted in push order, no loss or duplication.
REQ-037 Assert rst_i in WAIT_DONE with 3 queued -> next cycle level_o=0, res_valid_o=0, fun_start_o=0, no result emitted.
REQ-038 With FUN_DISPATCH_CNT_EN, 5 completed ops -> done_cnt_o=5.

Source files
------------

// File: rtl/fun_dispatch.sv
// fun_dispatch: operand queue feeding a multi-cycle compute stage.
// Operand pairs are buffered in a DEPTH-entry FIFO. A small FSM issues one
// operation at a time to the compute stage and captures its result into a
// valid/ready output register.
// Optional feature: define FUN_DISPATCH_CNT_EN to add the 16-bit done_cnt_o
// completion counter.
module fun_dispatch #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  in_a_i,
  input  logic [7:0]  in_b_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [7:0]  fun_a_o,
  output logic [7:0]  fun_b_o,
  output logic        fun_start_o,
  input  logic        fun_busy_i,
  input  logic [10:0] fun_y_i,
  output logic [10:0] res_y_o,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [4:0]  level_o
`ifdef FUN_DISPATCH_CNT_EN
  ,
  output logic [15:0] done_cnt_o
`endif
);

  localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]         level_q, level_d;
  logic               in_ready_q, in_ready_d;
  logic [7:0]         fun_a_q, fun_a_d;
  logic [7:0]         fun_b_q, fun_b_d;
  logic               fun_start_q, fun_start_d;
  logic [10:0]        res_y_q, res_y_d;
  logic               res_valid_q, res_valid_d;
  logic [15:0]        mem_q [DEPTH];

  logic               push_s;
  logic               pop_s;
  logic               deq_s;
  logic               cap_s;
  logic [15:0]        head_s;

  // Handshake qualifiers: accepted push, consumed result, dequeue and capture.
  always_comb begin
    push_s = in_valid_i & in_ready_q;
    pop_s  = res_valid_q & res_ready_i;
    // Issue only when the output slot is free now or is being freed this edge.
    deq_s  = (state_q == IDLE) & (level_q != 5'd0) & (~res_valid_q | res_ready_i);
    cap_s  = (state_q == WAIT_DONE) & ~fun_busy_i;
    head_s = mem_q[rd_ptr_q];
  end

  // Queue storage write port; contents need no reset since level gates reads.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {in_a_i, in_b_i};
    end
  end

  // Next-state computation for queue bookkeeping, FSM and output registers.
  always_comb begin
    state_d     = state_q;
    fun_a_d     = fun_a_q;
    fun_b_d     = fun_b_q;
    fun_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (deq_s) begin
          fun_a_d     = head_s[15:8];
          fun_b_d     = head_s[7:0];
          fun_start_d = 1'b1;
          state_d     = WAIT_BUSY;
        end else begin
          state_d     = IDLE;
        end
      end
      WAIT_BUSY: begin
        if (fun_busy_i) begin
          state_d = WAIT_DONE;
        end else begin
          state_d = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        if (!fun_busy_i) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (deq_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    level_d    = level_q + {4'd0, push_s} - {4'd0, deq_s};
    in_ready_d = (level_d != DEPTH_L);

    // A capture cannot coincide with a pop (issue needs a free slot), but
    // capture takes priority regardless.
    if (cap_s) begin
      res_y_d     = fun_y_i;
      res_valid_d = 1'b1;
    end else if (pop_s) begin
      res_y_d     = res_y_q;
      res_valid_d = 1'b0;
    end else begin
      res_y_d     = res_y_q;
      res_valid_d = res_valid_q;
    end
  end

  // FSM and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= 5'd0;
      in_ready_q  <= 1'b1;
      fun_a_q     <= 8'd0;
      fun_b_q     <= 8'd0;
      fun_start_q <= 1'b0;
      res_y_q     <= 11'd0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      in_ready_q  <= in_ready_d;
      fun_a_q     <= fun_a_d;
      fun_b_q     <= fun_b_d;
      fun_start_q <= fun_start_d;
      res_y_q     <= res_y_d;
      res_valid_q <= res_valid_d;
    end
  end

`ifdef FUN_DISPATCH_CNT_EN
  logic [15:0] done_cnt_q, done_cnt_d;

  // Completed-operation counter; wraps naturally at 16 bits.
  always_comb begin
    if (cap_s) begin
      done_cnt_d = done_cnt_q + 16'd1;
    end else begin
      done_cnt_d = done_cnt_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_cnt_q <= 16'd0;
    end else begin
      done_cnt_q <= done_cnt_d;
    end
  end

  assign done_cnt_o = done_cnt_q;
`endif

  assign in_ready_o  = in_ready_q;
  assign fun_a_o     = fun_a_q;
  assign fun_b_o     = fun_b_q;
  assign fun_start_o = fun_start_q;
  assign res_y_o     = res_y_q;
  assign res_valid_o = res_valid_q;
  assign level_o     = level_q;

endmodule

// File: tb/tb_fun_dispatch.sv
// Self-checking bench for fun_dispatch: table-driven single operations plus
// hand-written back-pressure and mid-operation reset sequences. Includes a
// behavioural compute stage that samples its operands when it finishes.
module tb_fun_dispatch;

  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  logic        clk;
  logic        rst_i;
  logic [7:0]  in_a, in_b;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  fun_a, fun_b;
  logic        fun_start;
  logic        fun_busy;
  logic [10:0] fun_y;
  logic [10:0] res_y;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  level;
`ifdef FUN_DISPATCH_CNT_EN
  logic [15:0] done_cnt;
`endif

  fun_dispatch #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_a_i      (in_a),
    .in_b_i      (in_b),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .fun_a_o     (fun_a),
    .fun_b_o     (fun_b),
    .fun_start_o (fun_start),
    .fun_busy_i  (fun_busy),
    .fun_y_i     (fun_y),
    .res_y_o     (res_y),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .level_o     (level)
`ifdef FUN_DISPATCH_CNT_EN
    ,
    .done_cnt_o  (done_cnt)
`endif
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [10:0] y;
  } vec_t;

  int          n_vec  = 0;
  int          n_miss = 0;
  int          cm_starts  = 0;
  int          cm_overlap = 0;
  logic [10:0] got_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [10:0] cbrt_mul(input logic [7:0] a, input logic [7:0] b);
    int r = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k * k * k <= int'(b)) r = k;
    end
    return 11'(int'(a) * r);
  endfunction

  // Compute stage model: busy one cycle after start, result computed from
  // the operands present when it finishes.
  initial begin
    int cm_state = 0;
    int cm_cnt   = 0;
    fun_busy = 1'b0;
    fun_y    = 11'd0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        cm_state = 0;
        fun_busy = 1'b0;
      end else if (cm_state == 0) begin
        if (fun_start) begin
          cm_starts++;
          cm_state = 1;
          cm_cnt   = LAT;
          fun_busy = 1'b1;
        end
      end else begin
        if (fun_start) cm_overlap++;
        if (cm_cnt == 0) begin
          fun_y    = cbrt_mul(fun_a, fun_b);
          fun_busy = 1'b0;
          cm_state = 0;
        end else begin
          cm_cnt--;
        end
      end
    end
  end

  // Result collector: records every result that is popped at the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_i && res_valid && res_ready) got_q.push_back(res_y);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_results(input int n, input int budget, input string nm);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(nm, got_q.size(), n);
  endtask

  vec_t vt [12];
  vec_t bp [7];
  int   s0;

  initial begin
    vt[0]  = '{a: 8'd5,   b: 8'd27,  y: 11'd15};
    vt[1]  = '{a: 8'd255, b: 8'd255, y: 11'd1530};
    vt[2]  = '{a: 8'd200, b: 8'd0,   y: 11'd0};
    vt[3]  = '{a: 8'd7,   b: 8'd8,   y: 11'd14};
    vt[4]  = '{a: 8'd3,   b: 8'd64,  y: 11'd12};
    vt[5]  = '{a: 8'd10,  b: 8'd1,   y: 11'd10};
    vt[6]  = '{a: 8'd1,   b: 8'd125, y: 11'd5};
    vt[7]  = '{a: 8'd9,   b: 8'd26,  y: 11'd18};
    vt[8]  = '{a: 8'd4,   b: 8'd63,  y: 11'd12};
    vt[9]  = '{a: 8'd100, b: 8'd216, y: 11'd600};
    vt[10] = '{a: 8'd2,   b: 8'd7,   y: 11'd2};
    vt[11] = '{a: 8'd11,  b: 8'd124, y: 11'd44};

    bp[0] = '{a: 8'd3,   b: 8'd27,  y: 11'd9};
    bp[1] = '{a: 8'd6,   b: 8'd8,   y: 11'd12};
    bp[2] = '{a: 8'd2,   b: 8'd200, y: 11'd10};
    bp[3] = '{a: 8'd50,  b: 8'd100, y: 11'd200};
    bp[4] = '{a: 8'd255, b: 8'd64,  y: 11'd1020};
    bp[5] = '{a: 8'd1,   b: 8'd1,   y: 11'd1};
    bp[6] = '{a: 8'd8,   b: 8'd8,   y: 11'd16};

    rst_i     = 1'b1;
    in_a      = 8'd0;
    in_b      = 8'd0;
    in_valid  = 1'b0;
    res_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_level", level, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_y", res_y, 0);
    chk("rst_start", fun_start, 0);
    chk("rst_fun_a", fun_a, 0);
    chk("rst_fun_b", fun_b, 0);
    rst_i = 1'b0;
    tick();
    chk("ready_after_rst", in_ready, 1);

    // Table-driven single operations with latency and pulse-width checks
    for (int i = 0; i < 12; i++) begin
      got_q.delete();
      s0 = cm_starts;
      in_a = vt[i].a;
      in_b = vt[i].b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("start_early", fun_start, 0);
      tick();
      chk("start_latency", fun_start, 1);
      chk("fun_a", fun_a, vt[i].a);
      chk("fun_b", fun_b, vt[i].b);
      tick();
      chk("start_width", fun_start, 0);
      wait_results(1, 40, "vec_timeout");
      if (got_q.size() > 0) chk("vec_y", got_q[0], vt[i].y);
      tick();
      tick();
      chk("vec_count", got_q.size(), 1);
      chk("vec_starts", cm_starts - s0, 1);
    end

    // Back-pressure: consumer stalled, DEPTH+2 pushes offered back to back
    got_q.delete();
    res_ready = 1'b0;
    s0 = cm_starts;
    for (int i = 0; i < DEPTH + 2; i++) begin
      chk("bp_ready", in_ready, (i < DEPTH + 1) ? 1 : 0);
      in_a = bp[i].a;
      in_b = bp[i].b;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_level", level, DEPTH);
    chk("bp_ready_full", in_ready, 0);
    chk("bp_res_valid", res_valid, 1);
    chk("bp_res_y", res_y, bp[0].y);
    in_a = bp[6].a;
    in_b = bp[6].b;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_y", res_y, bp[0].y);
      chk("bp_hold_valid", res_valid, 1);
      chk("bp_hold_level", level, DEPTH);
    end
    in_valid = 1'b0;
    chk("bp_one_start", cm_starts - s0, 1);
    res_ready = 1'b1;
    wait_results(DEPTH + 1, 200, "drain_timeout");
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i < got_q.size()) chk("drain_order", got_q[i], bp[i].y);
    end
    for (int i = 0; i < 20; i++) tick();
    chk("drain_count", got_q.size(), DEPTH + 1);
    chk("drain_level", level, 0);
    chk("drain_ready", in_ready, 1);

    // Reset while in WAIT_DONE with three entries queued
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      in_a = vt[i].a;
      in_b = vt[i].b;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_level", level, 3);
    rst_i = 1'b1;
    tick();
    chk("mid_rst_level", level, 0);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_start", fun_start, 0);
    rst_i = 1'b0;
    s0 = cm_starts;
    tick();
    chk("mid_rst_ready", in_ready, 1);
    for (int i = 0; i < 20; i++) tick();
    chk("mid_rst_no_result", got_q.size(), 0);
    chk("mid_rst_no_start", cm_starts - s0, 0);

    // Five queued operations after reset
    got_q.delete();
    for (int i = 0; i < 5; i++) begin
      in_a = vt[i + 5].a;
      in_b = vt[i + 5].b;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    wait_results(5, 200, "five_timeout");
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) chk("five_order", got_q[i], vt[i + 5].y);
    end
    tick();
    tick();
`ifdef FUN_DISPATCH_CNT_EN
    chk("done_cnt", done_cnt, 5);
`endif
    chk("no_overlap", cm_overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
